// File: rtl/log2_frac_pkg.sv
// log2_frac_pkg
//   Shared definitions for the fixed-point log2 stage:
//   - default input magnitude width and fractional width,
//   - derivation functions for the integer field and output widths,
//   - log2_frac_t, the packed {int, frac} result at default widths.
//   No ports (package).
package log2_frac_pkg;

    localparam int unsigned I_BW_DEF    = 32;
    localparam int unsigned FRAC_BW_DEF = 2;

    // The integer field must hold 0..I_BW+1 (I_BW+1 only reachable with rounding).
    function automatic int unsigned calc_int_bw(input int unsigned i_bw);
        return $clog2(i_bw + 2);
    endfunction

    function automatic int unsigned calc_o_bw(input int unsigned i_bw,
                                              input int unsigned frac_bw);
        return calc_int_bw(i_bw) + frac_bw;
    endfunction

    localparam int unsigned INT_BW_DEF = calc_int_bw(I_BW_DEF);
    localparam int unsigned O_BW_DEF   = calc_o_bw(I_BW_DEF, FRAC_BW_DEF);

    typedef struct packed {
        logic [INT_BW_DEF-1:0]  int_part;
        logic [FRAC_BW_DEF-1:0] frac_part;
    } log2_frac_t;

endpackage

// File: rtl/log2_lod.sv
// log2_lod
//   Combinational leading-one detector built as a binary tree of pairwise
//   merges. The input is zero-padded up to the next power of two.
//   Ports:
//     data_i  [W-1:0]          word to scan
//     pos_o   [$clog2(W)-1:0]  index of the highest set bit (0 when zero_o)
//     zero_o                   data_i is all zeros
module log2_lod #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0]         data_i,
    output logic [$clog2(W)-1:0] pos_o,
    output logic                 zero_o
);

    localparam int unsigned P_BW = $clog2(W);
    localparam int unsigned LVLS = P_BW;
    localparam int unsigned N    = 1 << LVLS;

    logic [N-1:0]    pad;
    logic            vld [0:LVLS][0:N-1];
    logic [P_BW-1:0] pos [0:LVLS][0:N-1];

    // Each node at level l covers 2**l bits; pos holds the index relative to
    // the node's subtree, so a hit in the upper half just sets bit l.
    always_comb begin
        pad = '0;
        pad[W-1:0] = data_i;
        for (int unsigned l = 0; l <= LVLS; l++) begin
            for (int unsigned n = 0; n < N; n++) begin
                vld[l][n] = 1'b0;
                pos[l][n] = '0;
            end
        end
        for (int unsigned n = 0; n < N; n++) begin
            vld[0][n] = pad[n];
        end
        for (int unsigned l = 0; l < LVLS; l++) begin
            for (int unsigned n = 0; n < (N >> (l + 1)); n++) begin
                vld[l+1][n] = vld[l][2*n+1] | vld[l][2*n];
                pos[l+1][n] = vld[l][2*n+1] ? (pos[l][2*n+1] | (P_BW'(1) << l))
                                            : pos[l][2*n];
            end
        end
    end

    assign pos_o  = pos[LVLS][0];
    assign zero_o = ~vld[LVLS][0];

endmodule

// File: rtl/log2_frac.sv
// log2_frac
//   Two-stage pipelined fixed-point log2 (Mitchell approximation).
//   data_o = {int, frac}: int = leading-one index + 1 (0 for a zero input),
//   frac = the FRAC_BW bits directly below the leading one, zero-filled.
//   Stage 1: leading-one detect. Stage 2: normalise, extract, optional round.
//   Build option: define LOG2_FRAC_ROUND_EN to round the fraction half-up
//   (carry-out clears frac and increments int); otherwise it is truncated.
//   Ports:
//     clk_i, rst_i (async, active-high)
//     en_i          gates input capture only
//     data_i [I_BW-1:0], valid_i, last_i   input stream
//     data_o [O_BW-1:0], valid_o, last_o   output stream, 2-cycle latency
module log2_frac
    import log2_frac_pkg::*;
#(
    parameter int unsigned I_BW    = I_BW_DEF,
    parameter int unsigned FRAC_BW = FRAC_BW_DEF,
    parameter int unsigned INT_BW  = calc_int_bw(I_BW),
    parameter int unsigned O_BW    = INT_BW + FRAC_BW
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            en_i,
    input  logic [I_BW-1:0] data_i,
    input  logic            valid_i,
    input  logic            last_i,
    output logic [O_BW-1:0] data_o,
    output logic            valid_o,
    output logic            last_o
);

    localparam int unsigned P_BW = $clog2(I_BW);

    // ---------------- stage 1: leading-one detect ----------------
    logic [P_BW-1:0] lod_p;
    logic            lod_zero;
    logic            accept;

    logic            s1_valid;
    logic            s1_last;
    logic            s1_zero;
    logic [P_BW-1:0] s1_p;
    logic [I_BW-1:0] s1_data;

    log2_lod #(
        .W (I_BW)
    ) u_lod (
        .data_i (data_i),
        .pos_o  (lod_p),
        .zero_o (lod_zero)
    );

    assign accept = valid_i & en_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_zero  <= 1'b0;
            s1_p     <= '0;
            s1_data  <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_last <= last_i;
                s1_zero <= lod_zero;
                s1_p    <= lod_p;
                s1_data <= data_i;
            end
        end
    end

    // ---------------- stage 2: normalise / extract / round ----------------
    logic [P_BW-1:0]    shamt;
    logic [INT_BW-1:0]  int_base;
    logic [INT_BW-1:0]  int_res;
    logic [FRAC_BW-1:0] frac_res;

    assign shamt    = P_BW'(I_BW - 1) - s1_p;
    assign int_base = s1_zero ? '0 : (INT_BW'(s1_p) + INT_BW'(1));

    // The word is extended by one zero LSB so the round bit always exists
    // (reads as 0 when there is nothing below the kept fraction). After the
    // shift the leading one sits at bit I_BW; the window starts below it.
`ifdef LOG2_FRAC_ROUND_EN
    localparam int unsigned WIN_BW = FRAC_BW + 1;
    logic [WIN_BW-1:0]  win;
    logic [FRAC_BW:0]   frac_sum;

    assign win      = WIN_BW'(({s1_data, 1'b0} << shamt) >> (I_BW - 1 - FRAC_BW));
    assign frac_sum = {1'b0, win[WIN_BW-1:1]} + (FRAC_BW + 1)'(win[0]);
    assign frac_res = frac_sum[FRAC_BW-1:0];
    assign int_res  = int_base + INT_BW'(frac_sum[FRAC_BW]);
`else
    localparam int unsigned WIN_BW = FRAC_BW;
    logic [WIN_BW-1:0]  win;

    assign win      = WIN_BW'(({s1_data, 1'b0} << shamt) >> (I_BW - FRAC_BW));
    assign frac_res = win;
    assign int_res  = int_base;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_o  <= '0;
            valid_o <= 1'b0;
            last_o  <= 1'b0;
        end else begin
            valid_o <= s1_valid;
            last_o  <= s1_valid & s1_last;
            if (s1_valid) begin
                data_o <= {int_res, frac_res};
            end
        end
    end

endmodule

// File: doc/log2_frac.md
# log2_frac

Pipelined, parametrised log2 stage for the acoustic front-end. It replaces the integer-only leading-ones-place log with a fixed-point result: an integer leading-one place plus `FRAC_BW` fractional bits taken from the bits below the leading one (Mitchell approximation). It sits between the energy/filterbank accumulator output and the downstream feature buffers. It keeps the same valid/last streaming contract, with no backpressure.

## Interface
- `I_BW`, default 32: input magnitude width; minimum 4.
- `FRAC_BW`, default 2: fractional output bits; range 1 to `I_BW-1`.
- `INT_BW`, default `$clog2(I_BW+2)`: integer field width. This is derived and must not be overridden.
- `O_BW`, default `INT_BW+FRAC_BW`: output width, 8 with the defaults.
- `clk_i`, input, 1: the single clock. All state is on the rising edge.
- `rst_i`, input, 1: reset, asynchronous and active-high.
- `en_i`, input, 1: block enable. It gates input capture only.
- `data_i`, input, `I_BW`: unsigned input sample.
- `valid_i`, input, 1: input sample valid.
- `last_i`, input, 1: last sample of a frame. It is meaningful only when `valid_i` is high.
- `data_o`, output, `O_BW`: `{int[INT_BW-1:0], frac[FRAC_BW-1:0]}`.
- `valid_o`, output, 1: output sample valid.
- `last_o`, output, 1: last flag aligned with `data_o`.

## Operation
- A sample is accepted when `valid_i & en_i` is high at a rising edge. Otherwise the stage-1 valid bit is cleared and the data registers hold.
- Integer field `int`:
  - p = index of the highest set bit of `data_i`; `int` = p+1.
  - Input 0 gives `int` = 0, which matches the legacy leading-ones-place convention.
- Fraction `frac`:
  - Shift `data_i` left by `I_BW-1-p` to normalise it. `frac` is the `FRAC_BW` bits directly below the leading one.
  - When fewer than `FRAC_BW` bits exist below the leading one, the missing bits are zero-filled from the right.
  - Input 0 gives `frac` = 0.
- `last` travels with its sample through the pipeline. `last_o = valid_o & last` of the sample in the output stage.
- The pipeline always advances; there is no stall. Samples already in flight drain normally when `en_i` falls.
- Back-to-back input (`valid_i` high on every cycle) is sustained at one sample per cycle.
- The output data registers hold their value when the corresponding stage valid bit is 0. Consumers must qualify `data_o` with `valid_o`.

## Timing
- Latency is exactly 2 cycles, from the accepting edge to `valid_o` high.
  - Stage 1: leading-one detect. Registers p, the zero flag, the input word, last, and valid.
  - Stage 2: normalise, extract the fraction, optionally round. Registers `data_o`, `valid_o`, `last_o`.
- Reset values: `data_o` = 0, `valid_o` = 0, `last_o` = 0. All internal stage registers are also 0.
- Asserting `rst_i` mid-frame clears both stages immediately (asynchronously). Samples in flight are discarded, and no partial `last_o` is emitted.
- The first sample can be accepted on the first rising edge after `rst_i` deasserts.
- Throughput is 1 sample per cycle. `valid_o` exactly reproduces the `valid_i & en_i` pattern, delayed by 2 cycles.

## Configuration
- `LOG2_FRAC_ROUND_EN` defined: the fraction is rounded half-up using the bit directly below the kept `FRAC_BW` bits.
  - The round bit is 0 if that bit does not exist.
  - Fraction carry-out clears `frac` to 0 and increments `int`.
  - Because `INT_BW` holds `I_BW+1`, all-ones input gives `int` = `I_BW+1`.
- `LOG2_FRAC_ROUND_EN` undefined: the fraction is truncated, and `int` never exceeds `I_BW`.
- Latency, port list, and reset behaviour are identical in both builds.

## Structure
- Package `log2_frac_pkg` holds:
  - default `I_BW`, `FRAC_BW`;
  - the `INT_BW`/`O_BW` derivation functions;
  - the packed output typedef `log2_frac_t` (`int` and `frac` fields).
- Sub-module `log2_lod`: combinational, parametrised leading-one detector returning p and a zero flag, built as a tree of pairwise merges. It is instantiated once, in stage 1.
- The normalising shifter and the rounding logic live in the top module, in stage 2.

## Test plan
Defaults are `I_BW`=32, `FRAC_BW`=2. Each result appears 2 cycles after acceptance.
- Inputs 0, 1, 2, 3, 6 -> `data_o` 0x00, 0x04, 0x08, 0x0A, 0x0E (round and truncate builds alike).
- Input 0x0000000F -> 0x13 truncated; 0x14 with `LOG2_FRAC_ROUND_EN`. Input 0xFFFFFFFF -> 0x83 truncated; 0x84 rounded.
- Stream of 5 back-to-back samples with `last_i` on the 5th -> five consecutive `valid_o` cycles, with `last_o` high only on the 5th.
- `valid_i` pattern 1,0,1,1 with `en_i` low on the 3rd cycle -> `valid_o` pattern 1,0,0,1, delayed 2 cycles. In-flight data is unaffected.
- `rst_i` pulsed while 2 samples are in flight, one carrying `last_i` -> `valid_o`, `last_o`, `data_o` = 0 immediately and on the next 2 cycles.
- Randomised 10k samples against a reference floor(log2)+Mitchell model, run for both macro settings -> zero mismatches.
